// File: rtl/binary_to_png.sv
// Single-channel pixel to 24-bit RGB colour mapper.
// Binary threshold, grey replicate or heatmap; one register stage.
module binary_to_png #(
  parameter int unsigned MODE     = 0,
  parameter logic [7:0]  THRESH   = 8'd128,
  parameter bit          INVERT   = 1'b0,
  parameter logic [23:0] FG_COLOR = 24'hFFFFFF,
  parameter logic [23:0] BG_COLOR = 24'h000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] binary_image_pixel,
  output logic [7:0] png_pixel_r,
  output logic [7:0] png_pixel_g,
  output logic [7:0] png_pixel_b
);

  localparam logic [1:0] MSEL = MODE[1:0];

  logic [7:0]  pix;
  logic        hit;
  logic [7:0]  ramp;
  logic [7:0]  ramp_n;
  logic [23:0] heat;
  logic [23:0] rgb_d;
  logic [23:0] rgb_q;

  assign pix    = binary_image_pixel;
  assign hit    = (pix >= THRESH) ^ INVERT;
  // 4*q and 255-4*q, with q the position inside a 64-wide band
  assign ramp   = {pix[5:0], 2'b00};
  assign ramp_n = ~ramp;

  always_comb begin
    heat = 24'h000000;
    unique case (pix[7:6])
      2'd0: heat = {8'h00, ramp, 8'hFF};
      2'd1: heat = {8'h00, 8'hFF, ramp_n};
      2'd2: heat = {ramp, 8'hFF, 8'h00};
      2'd3: heat = {8'hFF, ramp_n, 8'h00};
      default: heat = 24'hxxxxxx;
    endcase
  end

  always_comb begin
    rgb_d = hit ? FG_COLOR : BG_COLOR;
    case (MSEL)
      2'd1:    rgb_d = {pix, pix, pix};
      2'd2:    rgb_d = heat;
      default: rgb_d = hit ? FG_COLOR : BG_COLOR;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rgb_q <= 24'h000000;
    else      rgb_q <= rgb_d;
  end

  assign png_pixel_r = rgb_q[23:16];
  assign png_pixel_g = rgb_q[15:8];
  assign png_pixel_b = rgb_q[7:0];

endmodule

// File: tb/tb_binary_to_png.sv
// Scoreboard bench for binary_to_png: six configurations share one
// pixel stream; a spec-level model feeds a queue drained by a monitor.
module tb_binary_to_png;

  localparam int N = 6;
  localparam int          MD  [N] = '{0, 0, 1, 2, 3, 0};
  localparam int          TH  [N] = '{128, 16, 128, 128, 200, 0};
  localparam int          INV [N] = '{0, 1, 0, 0, 0, 1};
  localparam logic [23:0] FG  [N] = '{24'hFFFFFF, 24'hFF0000, 24'hFFFFFF,
                                      24'hFFFFFF, 24'h123456, 24'hFFFFFF};
  localparam logic [23:0] BG  [N] = '{24'h000000, 24'h0000FF, 24'h000000,
                                      24'h000000, 24'hABCDEF, 24'h00FF00};

  typedef logic [N-1:0][23:0] exp_t;

  logic       clk;
  logic       rst;
  logic [7:0] pix;
  logic [7:0] r [N];
  logic [7:0] g [N];
  logic [7:0] b [N];

  exp_t exp_q [$];
  int   errors;
  int   checks;
  int   pushes;
  int   pops;

  for (genvar i = 0; i < N; i++) begin : g_dut
    binary_to_png #(
      .MODE     (MD[i]),
      .THRESH   (TH[i][7:0]),
      .INVERT   (INV[i] != 0),
      .FG_COLOR (FG[i]),
      .BG_COLOR (BG[i])
    ) u_dut (
      .clk                (clk),
      .rst                (rst),
      .binary_image_pixel (pix),
      .png_pixel_r        (r[i]),
      .png_pixel_g        (g[i]),
      .png_pixel_b        (b[i])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [23:0] ref_map(int k, int p);
    int rr, gg, bb;
    bit h;
    rr = 0; gg = 0; bb = 0;
    if (MD[k] == 1) begin
      rr = p; gg = p; bb = p;
    end else if (MD[k] == 2) begin
      if (p < 64) begin
        rr = 0; gg = 4 * p; bb = 255;
      end else if (p < 128) begin
        rr = 0; gg = 255; bb = 255 - 4 * (p - 64);
      end else if (p < 192) begin
        rr = 4 * (p - 128); gg = 255; bb = 0;
      end else begin
        rr = 255; gg = 255 - 4 * (p - 192); bb = 0;
      end
    end else begin
      h = (p >= TH[k]) != (INV[k] != 0);
      return h ? FG[k] : BG[k];
    end
    return {rr[7:0], gg[7:0], bb[7:0]};
  endfunction

  function automatic exp_t model(int p);
    exp_t e;
    for (int k = 0; k < N; k++) e[k] = ref_map(k, p);
    return e;
  endfunction

  task automatic check(string name, int k, logic [23:0] act, logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst=%0d pix=%02h got=%06h expected=%06h",
               name, k, pix, act, exp);
    end
  endtask

  task automatic check_zero(string name);
    for (int k = 0; k < N; k++)
      check(name, k, {r[k], g[k], b[k]}, 24'h000000);
  endtask

  task automatic drive(int p);
    @(negedge clk);
    pix = p[7:0];
    exp_q.push_back(model(p));
    pushes++;
  endtask

  // Monitor: every edge out of reset retires one queued expectation
  always @(posedge clk) begin
    #1;
    if (rst && exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      pops++;
      for (int k = 0; k < N; k++)
        check("map", k, {r[k], g[k], b[k]}, e[k]);
    end
  end

  int dir [17] = '{'h7F, 'h80, 'hFF, 'h0F, 'h10, 'h00, 'h5A, 'h3F, 'h40,
                   'h7F, 'h80, 'hBF, 'hC0, 'hFF, 'hC7, 'hC8, 'h01};

  initial begin
    errors = 0; checks = 0; pushes = 0; pops = 0;
    rst = 1'b0;
    pix = 8'hFF;
    repeat (3) begin
      @(negedge clk);
      check_zero("reset_hold");
    end

    @(negedge clk);
    rst = 1'b1;
    pix = dir[0][7:0];
    exp_q.push_back(model(dir[0]));
    pushes++;
    for (int i = 1; i < 17; i++) drive(dir[i]);

    // Asynchronous reset between edges
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check_zero("async_reset");
    repeat (2) begin
      @(negedge clk);
      pix = 8'($urandom_range(0, 255));
      check_zero("reset_midstream");
    end
    @(negedge clk);
    rst = 1'b1;
    pix = 8'h93;
    exp_q.push_back(model('h93));
    pushes++;

    for (int i = 0; i < 65536; i++) drive(int'($urandom_range(0, 255)));

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0 || pops != pushes) begin
      errors++;
      $display("FAIL drain got=%0d/%0d left=%0d expected=all retired",
               pops, pushes, exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
